// File: rtl/alu_pkg.sv
// alu_pkg: op codes and flag-register bit positions shared by the ALU, its interface and the bench
package alu_pkg;
    // 001 and 111 are reserved encodings; they produce a zero result
    typedef enum logic [2:0] {
        PASS_B = 3'b000,
        ADD    = 3'b010,
        SUB    = 3'b011,
        AND    = 3'b100,
        OR     = 3'b101,
        XOR    = 3'b110
    } alu_op_e;
    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;
endpackage

// File: rtl/pipelined_alu_if.sv
// pipelined_alu_if: operand/result handshake bundle for pipelined_alu
//   master drives in_valid, a, b, cntrl, set_flags, out_ready
//   slave  drives in_ready, out_valid, result, negative, zero, overflow, carry_out, flags_q
interface pipelined_alu_if #(parameter int WIDTH = 64);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       cntrl;
    logic             set_flags;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             negative;
    logic             zero;
    logic             overflow;
    logic             carry_out;
    logic [3:0]       flags_q;
    modport master (
        output in_valid, a, b, cntrl, set_flags, out_ready,
        input  in_ready, out_valid, result, negative, zero, overflow, carry_out, flags_q
    );
    modport slave (
        input  in_valid, a, b, cntrl, set_flags, out_ready,
        output in_ready, out_valid, result, negative, zero, overflow, carry_out, flags_q
    );
endinterface

// File: rtl/alu_slice.sv
// alu_slice: combinational W-bit ALU slice
//   a, b, cntrl, cin in; res, cout (carry out of top bit), cin_msb (carry into top bit) out
module alu_slice
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   cntrl,
    input  logic         cin,
    output logic [W-1:0] res,
    output logic         cout,
    output logic         cin_msb
);
    logic [W-1:0] bx;
    logic [W:0]   sum;
    always_comb begin
        bx      = (cntrl == SUB) ? ~b : b;
        sum     = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, cin};
        cout    = sum[W];
        // sum bit = a ^ b ^ carry-in, so the carry into the top bit falls out directly
        cin_msb = a[W-1] ^ bx[W-1] ^ sum[W-1];
        case (cntrl)
            PASS_B:   res = b;
            ADD, SUB: res = sum[W-1:0];
            AND:      res = a & b;
            OR:       res = a | b;
            XOR:      res = a ^ b;
            default:  res = '0;
        endcase
    end
endmodule

// File: rtl/pipelined_alu.sv
// pipelined_alu: two-stage ALU, low SPLIT bits in stage 1, high bits with registered carry in stage 2
//   clk, reset_n (async, active low); bus: pipelined_alu_if.slave carrying both handshakes,
//   operands, per-op N/Z/V/C and the architectural flag register flags_q
module pipelined_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SPLIT = WIDTH / 2
) (
    input  logic clk,
    input  logic reset_n,
    pipelined_alu_if.slave bus
);
    localparam int HW = WIDTH - SPLIT;
    logic             s1_valid_q;
    logic [SPLIT-1:0] s1_lo_q;
    logic             s1_c_q;
    logic [HW-1:0]    s1_ahi_q;
    logic [HW-1:0]    s1_bhi_q;
    logic [2:0]       s1_op_q;
    logic             s1_sf_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] res_q;
    logic [3:0]       nzvc_q;
    logic             out_sf_q;
    logic [3:0]       arch_flags_q;
    logic [WIDTH-1:0] res_d;
    logic [3:0]       nzvc_d;
    logic [SPLIT-1:0] lo_res;
    logic             lo_c;
    logic             lo_unused;
    logic [HW-1:0]    hi_res;
    logic             hi_c;
    logic             hi_cm;
    logic             s2_adv;
    logic             accept;
    logic             arith;
    alu_slice #(.W(SPLIT)) u_lo (
        .a       (bus.a[SPLIT-1:0]),
        .b       (bus.b[SPLIT-1:0]),
        .cntrl   (bus.cntrl),
        .cin     (bus.cntrl == SUB),
        .res     (lo_res),
        .cout    (lo_c),
        .cin_msb (lo_unused)
    );
    alu_slice #(.W(HW)) u_hi (
        .a       (s1_ahi_q),
        .b       (s1_bhi_q),
        .cntrl   (s1_op_q),
        .cin     (s1_c_q),
        .res     (hi_res),
        .cout    (hi_c),
        .cin_msb (hi_cm)
    );
    always_comb begin
        s2_adv         = !out_valid_q | bus.out_ready;
        accept         = bus.in_valid & (!s1_valid_q | s2_adv);
        arith          = (s1_op_q == ADD) || (s1_op_q == SUB);
        res_d          = {hi_res, s1_lo_q};
        nzvc_d         = '0;
        nzvc_d[FLAG_N] = res_d[WIDTH-1];
        nzvc_d[FLAG_Z] = (res_d == '0);
        nzvc_d[FLAG_V] = arith & (hi_cm ^ hi_c);
        nzvc_d[FLAG_C] = arith & hi_c;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q   <= 1'b0;
            s1_lo_q      <= '0;
            s1_c_q       <= 1'b0;
            s1_ahi_q     <= '0;
            s1_bhi_q     <= '0;
            s1_op_q      <= '0;
            s1_sf_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            res_q        <= '0;
            nzvc_q       <= '0;
            out_sf_q     <= 1'b0;
            arch_flags_q <= '0;
        end else begin
            if (accept) begin
                s1_lo_q  <= lo_res;
                s1_c_q   <= lo_c;
                s1_ahi_q <= bus.a[WIDTH-1:SPLIT];
                s1_bhi_q <= bus.b[WIDTH-1:SPLIT];
                s1_op_q  <= bus.cntrl;
                s1_sf_q  <= bus.set_flags;
            end
            // stage 1 empties when it advances unless refilled on the same edge
            if (accept | s2_adv)
                s1_valid_q <= accept;
            if (s2_adv)
                out_valid_q <= s1_valid_q;
            if (s2_adv & s1_valid_q) begin
                res_q    <= res_d;
                nzvc_q   <= nzvc_d;
                out_sf_q <= s1_sf_q;
            end
            if (out_valid_q & bus.out_ready & out_sf_q)
                arch_flags_q <= nzvc_q;
        end
    end
    assign bus.in_ready  = !s1_valid_q | s2_adv;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = res_q;
    assign bus.negative  = nzvc_q[FLAG_N];
    assign bus.zero      = nzvc_q[FLAG_Z];
    assign bus.overflow  = nzvc_q[FLAG_V];
    assign bus.carry_out = nzvc_q[FLAG_C];
    assign bus.flags_q   = arch_flags_q;
endmodule
